// File: rtl/clkdiv_pkg.sv
// Shared constants and FSM state encoding for the clock divider controller.
package clkdiv_pkg;

    localparam int CNT_W    = 13;
    localparam int DEF_HALF = 256;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_PEND,
        ST_STOP
    } state_t;

endpackage

// File: rtl/clkdiv_phase_cnt.sv
// Half-period counter and divided-clock toggle flop.
// wrap is high whenever the count has reached the half-period.
module clkdiv_phase_cnt #(
    parameter int CNT_W = clkdiv_pkg::CNT_W
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             enable,
    input  logic [CNT_W-1:0] half,
    output logic             wrap,
    output logic             div_clk
);

    logic [CNT_W-1:0] cnt;

    // cnt is 0 while idle and half is never 0, so wrap stays low there
    assign wrap = (cnt == half);

    always_ff @(posedge clk) begin
        if (clear) begin
            cnt     <= '0;
            div_clk <= 1'b0;
        end else if (enable) begin
            if (wrap) begin
                cnt     <= CNT_W'(1);
                div_clk <= ~div_clk;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/clkdiv_ctrl.sv
// Programmable clock divider: run/stop sequencing and half-period update handshake.
// New half-periods are applied only on the falling edge of div_clk so no short phase is ever produced.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | stopped, div_clk low, counter cleared, config applies now
//   ST_RUN  | dividing, config requests accepted
//   ST_PEND | dividing, accepted value held until next 1->0 toggle
//   ST_STOP | run dropped while high, finishing the high phase
module clkdiv_ctrl #(
    parameter int CNT_W    = clkdiv_pkg::CNT_W,
    parameter int DEF_HALF = clkdiv_pkg::DEF_HALF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             cfg_valid,
    input  logic [CNT_W-1:0] cfg_half,
    output logic             cfg_ready,
    output logic             div_clk,
    output logic             tick,
    output logic             cfg_err,
    output logic             busy,
    output logic [CNT_W-1:0] active_half
);

    import clkdiv_pkg::*;

    state_t           state, state_nx;
    logic [CNT_W-1:0] pend_half;
    logic             pend_valid;
    logic             accept, accept_ok;
    logic             wrap, fall;
    logic             load_now, latch_pend, apply_pend;
    logic             clear, enable;

    assign cfg_ready = (state == ST_IDLE) || (state == ST_RUN);
    assign busy      = (state != ST_IDLE);
    assign accept    = cfg_valid && cfg_ready;
    assign accept_ok = accept && (cfg_half != '0);
    assign fall      = wrap && div_clk;

    always_comb begin
        state_nx   = state;
        load_now   = 1'b0;
        latch_pend = 1'b0;
        apply_pend = 1'b0;
        case (state)
            ST_IDLE: begin
                load_now = accept_ok;
                if (run) state_nx = ST_RUN;
            end
            ST_RUN: begin
                // a falling toggle on this edge is as safe a stop point as div_clk=0
                if (!run && (!div_clk || fall)) begin
                    state_nx = ST_IDLE;
                    load_now = accept_ok;
                end else if (!run) begin
                    state_nx   = ST_STOP;
                    latch_pend = accept_ok;
                end else if (accept_ok) begin
                    state_nx   = ST_PEND;
                    latch_pend = 1'b1;
                end
            end
            ST_PEND: begin
                if (!run && (!div_clk || fall)) begin
                    state_nx   = ST_IDLE;
                    apply_pend = 1'b1;
                end else if (!run) begin
                    state_nx = ST_STOP;
                end else if (fall) begin
                    state_nx   = ST_RUN;
                    apply_pend = 1'b1;
                end
            end
            ST_STOP: begin
                if (fall) begin
                    state_nx   = ST_IDLE;
                    apply_pend = pend_valid;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    assign clear  = rst || (state_nx == ST_IDLE);
    assign enable = run || (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            active_half <= CNT_W'(DEF_HALF);
            pend_half   <= '0;
            pend_valid  <= 1'b0;
            tick        <= 1'b0;
            cfg_err     <= 1'b0;
        end else begin
            state   <= state_nx;
            cfg_err <= accept && (cfg_half == '0);
            tick    <= !clear && enable && wrap && !div_clk;
            if (load_now) begin
                active_half <= cfg_half;
            end else if (apply_pend) begin
                active_half <= pend_half;
            end
            if (latch_pend) begin
                pend_half  <= cfg_half;
                pend_valid <= 1'b1;
            end else if (apply_pend) begin
                pend_valid <= 1'b0;
            end
        end
    end

    clkdiv_phase_cnt #(.CNT_W(CNT_W)) u_phase_cnt (
        .clk     (clk),
        .clear   (clear),
        .enable  (enable),
        .half    (active_half),
        .wrap    (wrap),
        .div_clk (div_clk)
    );

endmodule

// File: tb/tb_clkdiv_ctrl.sv
// Directed bench for clkdiv_ctrl: vector table plus hand-written multi-cycle sequences.
module tb_clkdiv_ctrl;

    localparam int W = 13;

    logic         clk = 1'b0;
    logic         rst, run, cfg_valid;
    logic [W-1:0] cfg_half;
    logic         cfg_ready, div_clk, tick, cfg_err, busy;
    logic [W-1:0] active_half;

    int tests = 0;
    int fails = 0;

    clkdiv_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .run         (run),
        .cfg_valid   (cfg_valid),
        .cfg_half    (cfg_half),
        .cfg_ready   (cfg_ready),
        .div_clk     (div_clk),
        .tick        (tick),
        .cfg_err     (cfg_err),
        .busy        (busy),
        .active_half (active_half)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         run;
        logic         cv;
        logic [W-1:0] half;
        int           n;
        logic         div;
        logic         tk;
        logic         bsy;
        logic         rdy;
        logic         err;
        logic [W-1:0] act;
    } vec_t;

    vec_t tbl [20];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic wait_div(input logic val, input int maxc, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (div_clk !== val && n < maxc);
        check("wait_div_bound", {31'd0, div_clk}, {31'd0, val});
    endtask

    task automatic do_reset();
        rst = 1'b1;
        run = 1'b0;
        cfg_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int n, n2, highs, ticks, idles;

        //          run cv half n  div tk bsy rdy err act
        tbl[0]  = '{1'b0, 1'b1, 13'd3, 1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 13'd3};
        tbl[1]  = '{1'b0, 1'b1, 13'd0, 1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 13'd3};
        tbl[2]  = '{1'b0, 1'b0, 13'd0, 1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 13'd3};
        tbl[3]  = '{1'b1, 1'b0, 13'd0, 1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 13'd3};
        tbl[4]  = '{1'b1, 1'b0, 13'd0, 2, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 13'd3};
        tbl[5]  = '{1'b1, 1'b0, 13'd0, 1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 13'd3};
        tbl[6]  = '{1'b1, 1'b0, 13'd0, 1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 13'd3};
        tbl[7]  = '{1'b1, 1'b0, 13'd0, 1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 13'd3};
        tbl[8]  = '{1'b1, 1'b0, 13'd0, 1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 13'd3};
        tbl[9]  = '{1'b1, 1'b1, 13'd0, 1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 13'd3};
        tbl[10] = '{1'b1, 1'b1, 13'd5, 1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 13'd3};
        tbl[11] = '{1'b1, 1'b0, 13'd0, 1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 13'd3};
        tbl[12] = '{1'b1, 1'b0, 13'd0, 2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 13'd3};
        tbl[13] = '{1'b1, 1'b0, 13'd0, 1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 13'd5};
        tbl[14] = '{1'b1, 1'b0, 13'd0, 4, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 13'd5};
        tbl[15] = '{1'b1, 1'b0, 13'd0, 1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 13'd5};
        tbl[16] = '{1'b0, 1'b0, 13'd0, 1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 13'd5};
        tbl[17] = '{1'b1, 1'b0, 13'd0, 3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 13'd5};
        tbl[18] = '{1'b1, 1'b0, 13'd0, 1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 13'd5};
        tbl[19] = '{1'b0, 1'b0, 13'd0, 1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 13'd5};

        rst = 1'b1;
        run = 1'b0;
        cfg_valid = 1'b0;
        cfg_half = '0;
        repeat (2) @(negedge clk);
        check("rst_div", {31'd0, div_clk}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_ready", {31'd0, cfg_ready}, 32'd1);
        check("rst_tick", {31'd0, tick}, 32'd0);
        check("rst_err", {31'd0, cfg_err}, 32'd0);
        check("rst_active", {19'd0, active_half}, 32'd256);
        rst = 1'b0;

        // default half-period: first rise 256 edges after the run edge, period 512
        run = 1'b1;
        wait_div(1'b1, 300, n);
        check("first_rise_256", n, 32'd257);
        check("first_tick", {31'd0, tick}, 32'd1);
        highs = 0; ticks = 0; idles = 0;
        for (int i = 1; i <= 512; i++) begin
            @(negedge clk);
            highs += int'(div_clk);
            ticks += int'(tick);
            idles += int'(!busy);
        end
        check("period512_high", highs, 32'd256);
        check("period512_ticks", ticks, 32'd1);
        check("period512_busy", idles, 32'd0);
        check("period512_rise", {31'd0, div_clk}, 32'd1);

        do_reset();
        for (int i = 0; i < 20; i++) begin
            run = tbl[i].run;
            cfg_valid = tbl[i].cv;
            cfg_half = tbl[i].half;
            repeat (tbl[i].n) @(negedge clk);
            check($sformatf("row%0d_div", i), {31'd0, div_clk}, {31'd0, tbl[i].div});
            check($sformatf("row%0d_tick", i), {31'd0, tick}, {31'd0, tbl[i].tk});
            check($sformatf("row%0d_busy", i), {31'd0, busy}, {31'd0, tbl[i].bsy});
            check($sformatf("row%0d_ready", i), {31'd0, cfg_ready}, {31'd0, tbl[i].rdy});
            check($sformatf("row%0d_err", i), {31'd0, cfg_err}, {31'd0, tbl[i].err});
            check($sformatf("row%0d_active", i), {19'd0, active_half}, {19'd0, tbl[i].act});
        end

        // reset while a value is pending
        cfg_valid = 1'b1; cfg_half = 13'd4;
        @(negedge clk);
        cfg_valid = 1'b0; run = 1'b1;
        wait_div(1'b1, 20, n);
        check("h4_first_rise", n, 32'd5);
        cfg_valid = 1'b1; cfg_half = 13'd8;
        @(negedge clk);
        cfg_valid = 1'b0;
        check("pend_ready", {31'd0, cfg_ready}, 32'd0);
        check("pend_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_pend_busy", {31'd0, busy}, 32'd0);
        check("rst_pend_ready", {31'd0, cfg_ready}, 32'd1);
        check("rst_pend_div", {31'd0, div_clk}, 32'd0);
        check("rst_pend_active", {19'd0, active_half}, 32'd256);
        repeat (20) @(negedge clk);
        check("rst_pend_discard", {19'd0, active_half}, 32'd256);
        do_reset();

        // H=4, run dropped during the second high cycle
        cfg_valid = 1'b1; cfg_half = 13'd4;
        @(negedge clk);
        cfg_valid = 1'b0; run = 1'b1;
        wait_div(1'b1, 20, n);
        @(negedge clk);
        run = 1'b0;
        @(negedge clk);
        check("stop_busy", {31'd0, busy}, 32'd1);
        check("stop_ready", {31'd0, cfg_ready}, 32'd0);
        check("stop_div1", {31'd0, div_clk}, 32'd1);
        @(negedge clk);
        check("stop_div2", {31'd0, div_clk}, 32'd1);
        @(negedge clk);
        check("stop_fall_div", {31'd0, div_clk}, 32'd0);
        check("stop_idle_busy", {31'd0, busy}, 32'd0);
        check("stop_idle_ready", {31'd0, cfg_ready}, 32'd1);

        // request held through PEND, second value taken only after return to RUN
        run = 1'b1;
        wait_div(1'b1, 20, n);
        cfg_valid = 1'b1; cfg_half = 13'd8;
        @(negedge clk);
        check("hold_pend_ready", {31'd0, cfg_ready}, 32'd0);
        cfg_half = 13'd6;
        wait_div(1'b0, 20, n);
        check("hold_fall_active8", {19'd0, active_half}, 32'd8);
        check("hold_fall_ready", {31'd0, cfg_ready}, 32'd1);
        @(negedge clk);
        cfg_valid = 1'b0;
        check("hold_second_ready", {31'd0, cfg_ready}, 32'd0);
        check("hold_second_active", {19'd0, active_half}, 32'd8);
        wait_div(1'b1, 40, n);
        wait_div(1'b0, 40, n2);
        check("hold_period16", n + n2 + 1, 32'd16);
        check("hold_active6", {19'd0, active_half}, 32'd6);
        check("hold_back_ready", {31'd0, cfg_ready}, 32'd1);
        wait_div(1'b1, 40, n);
        wait_div(1'b0, 40, n2);
        check("hold_period12", n + n2, 32'd12);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
